// File: rtl/incidentiq_pkg.sv
// rtl/incidentiq_pkg.sv - shared types, constants and saturating helpers
//
// Purpose : alarm FSM state encoding, event type codes, event record width
//           and signed saturating add/subtract used for release levels.
// Ports   : none (package).

package incidentiq_pkg;

  localparam int EVT_W = 34;

  typedef enum logic [2:0] {
    NORMAL     = 3'd0,
    HIGH_PEND  = 3'd1,
    HIGH_ALARM = 3'd2,
    LOW_PEND   = 3'd3,
    LOW_ALARM  = 3'd4
  } alarm_state_t;

  typedef enum logic [1:0] {
    EVT_NONE = 2'd0,
    HIGH_SET = 2'd1,
    LOW_SET  = 2'd2,
    CLEAR    = 2'd3
  } evt_type_t;

  // Clamp a 33-bit signed intermediate into the signed range of a w-bit word.
  function automatic logic signed [31:0] sat_to_w(input logic signed [32:0] s,
                                                   input int unsigned w);
    logic signed [32:0] max_v;
    logic signed [32:0] min_v;
    logic signed [32:0] r;
    max_v = (33'sd1 <<< (w - 1)) - 33'sd1;
    min_v = -(33'sd1 <<< (w - 1));
    r = s;
    if (s > max_v) begin
      r = max_v;
    end else if (s < min_v) begin
      r = min_v;
    end
    return r[31:0];
  endfunction

  function automatic logic signed [31:0] sat_add_s(input logic signed [31:0] a,
                                                    input logic signed [31:0] b,
                                                    input int unsigned w);
    logic signed [32:0] s;
    s = {a[31], a} + {b[31], b};
    return sat_to_w(s, w);
  endfunction

  function automatic logic signed [31:0] sat_sub_s(input logic signed [31:0] a,
                                                    input logic signed [31:0] b,
                                                    input int unsigned w);
    logic signed [32:0] s;
    s = {a[31], a} - {b[31], b};
    return sat_to_w(s, w);
  endfunction

endpackage

// File: rtl/temp_alarm_qualifier_if.sv
// rtl/temp_alarm_qualifier_if.sv - alarm/clear event stream interface
//
// Purpose : valid/ready event stream from the qualifier to the incident logic.
// Signals : evt_valid (head entry present), evt_data {type, seq, temp},
//           evt_ready (consumer pops on evt_valid & evt_ready).
// Modports: master = event producer, slave = event consumer.

interface temp_alarm_qualifier_if;

  logic                             evt_valid;
  logic [incidentiq_pkg::EVT_W-1:0] evt_data;
  logic                             evt_ready;

  modport master (output evt_valid, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_data, output evt_ready);

endinterface

// File: rtl/evt_fifo.sv
// rtl/evt_fifo.sv - first-word fall-through synchronous FIFO
//
// Purpose : event queue; head is visible whenever the FIFO is non-empty.
// Ports   : clk, reset_n (async, active-low), push/push_data, pop,
//           full, empty, head (zero while empty).
// A push while full is accepted only if a pop happens on the same cycle.

module evt_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         pop_en;
  logic         push_en;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);
  assign head    = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/temp_alarm_qualifier.sv
// rtl/temp_alarm_qualifier.sv - temperature alarm qualification with debounce/hysteresis
//
// Purpose : qualifies each raw sample against t_high/t_low, raises a
//           registered warning, queues timestamped alarm/clear events and
//           tracks min/max since the last stats clear.
// Ports   : clk, reset_n (async, active-low)
//           temp_valid/temp_code  sample strobe and signed sample
//           t_high/t_low/hyst     thresholds (signed) and hysteresis (unsigned)
//           stats_clr             resets min/max tracking
//           warning, alarm_state  alarm status
//           evt_if (master)       event stream {type, seq, temp}
//           drop_cnt              events lost to a full queue (saturating)
//           temp_min/temp_max     signed extremes since the last clear

module temp_alarm_qualifier
  import incidentiq_pkg::*;
#(
  parameter int DEBOUNCE  = 3,
  parameter int EVT_DEPTH = 4,
  parameter int TW        = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 temp_valid,
  input  logic signed [TW-1:0] temp_code,
  input  logic signed [TW-1:0] t_high,
  input  logic signed [TW-1:0] t_low,
  input  logic        [TW-2:0] hyst,
  input  logic                 stats_clr,
  output logic                 warning,
  output logic [2:0]           alarm_state,
  temp_alarm_qualifier_if.master evt_if,
  output logic [7:0]           drop_cnt,
  output logic signed [TW-1:0] temp_min,
  output logic signed [TW-1:0] temp_max
);

  localparam logic signed [TW-1:0] T_MAX = {1'b0, {(TW-1){1'b1}}};
  localparam logic signed [TW-1:0] T_MIN = {1'b1, {(TW-1){1'b0}}};

  alarm_state_t        state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [15:0]         seq_q, seq_d;
  logic                warning_q, warning_d;
  logic [7:0]          drop_q, drop_d;
  logic signed [TW-1:0] min_q, min_d;
  logic signed [TW-1:0] max_q, max_d;

  logic                above, below;
  logic signed [31:0]  th_w, tl_w, hy_w;
  logic signed [TW-1:0] rel_hi, rel_lo;
  logic                push;
  evt_type_t           push_type;
  logic [EVT_W-1:0]    push_data;
  logic                fifo_full, fifo_empty, fifo_pop;

  // Release levels are computed wide and clamped so an extreme hysteresis
  // can never wrap around to the opposite end of the range.
  always_comb begin
    th_w   = 32'(t_high);
    tl_w   = 32'(t_low);
    hy_w   = 32'(hyst);
    rel_hi = TW'(sat_sub_s(th_w, hy_w, TW));
    rel_lo = TW'(sat_add_s(tl_w, hy_w, TW));
  end

  // With inverted thresholds a sample can be both; "above" wins.
  assign above = temp_code > t_high;
  assign below = (temp_code < t_low) && !above;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_type = EVT_NONE;
    if (temp_valid) begin
      case (state_q)
        NORMAL: begin
          if (above) begin
            if (DEBOUNCE == 1) begin
              state_d   = HIGH_ALARM;
              push      = 1'b1;
              push_type = HIGH_SET;
            end else begin
              state_d = HIGH_PEND;
              cnt_d   = 4'd1;
            end
          end else if (below) begin
            if (DEBOUNCE == 1) begin
              state_d   = LOW_ALARM;
              push      = 1'b1;
              push_type = LOW_SET;
            end else begin
              state_d = LOW_PEND;
              cnt_d   = 4'd1;
            end
          end
        end
        HIGH_PEND: begin
          if (above) begin
            if (cnt_q + 4'd1 == 4'(DEBOUNCE)) begin
              state_d   = HIGH_ALARM;
              cnt_d     = 4'd0;
              push      = 1'b1;
              push_type = HIGH_SET;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = NORMAL;
            cnt_d   = 4'd0;
          end
        end
        LOW_PEND: begin
          if (below) begin
            if (cnt_q + 4'd1 == 4'(DEBOUNCE)) begin
              state_d   = LOW_ALARM;
              cnt_d     = 4'd0;
              push      = 1'b1;
              push_type = LOW_SET;
            end else begin
              cnt_d = cnt_q + 4'd1;
            end
          end else begin
            state_d = NORMAL;
            cnt_d   = 4'd0;
          end
        end
        HIGH_ALARM: begin
          if (temp_code <= rel_hi) begin
            state_d   = NORMAL;
            push      = 1'b1;
            push_type = CLEAR;
          end
        end
        LOW_ALARM: begin
          // A jump straight into the high range clears first; high
          // qualification starts over from the following sample.
          if ((temp_code >= rel_lo) || above) begin
            state_d   = NORMAL;
            push      = 1'b1;
            push_type = CLEAR;
          end
        end
        default: begin
          state_d = NORMAL;
          cnt_d   = 4'd0;
        end
      endcase
    end
    warning_d = (state_d == HIGH_ALARM) || (state_d == LOW_ALARM);
  end

  // seq stamps the event with the sample count before this sample.
  always_comb begin
    seq_d     = temp_valid ? seq_q + 16'd1 : seq_q;
    push_data = EVT_W'({push_type, seq_q, temp_code});
  end

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (stats_clr) begin
      min_d = T_MAX;
      max_d = T_MIN;
    end else if (temp_valid) begin
      if (temp_code < min_q) min_d = temp_code;
      if (temp_code > max_q) max_d = temp_code;
    end
  end

  assign fifo_pop = evt_if.evt_ready && !fifo_empty;

  always_comb begin
    drop_d = drop_q;
    if (push && fifo_full && !fifo_pop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= NORMAL;
      cnt_q     <= 4'd0;
      seq_q     <= 16'd0;
      warning_q <= 1'b0;
      drop_q    <= 8'd0;
      min_q     <= T_MAX;
      max_q     <= T_MIN;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      seq_q     <= seq_d;
      warning_q <= warning_d;
      drop_q    <= drop_d;
      min_q     <= min_d;
      max_q     <= max_d;
    end
  end

  evt_fifo #(
    .W     (EVT_W),
    .DEPTH (EVT_DEPTH)
  ) u_evt_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (evt_if.evt_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (evt_if.evt_data)
  );

  assign evt_if.evt_valid = !fifo_empty;
  assign warning          = warning_q;
  assign alarm_state      = state_q;
  assign drop_cnt         = drop_q;
  assign temp_min         = min_q;
  assign temp_max         = max_q;

endmodule

// File: tb/tb_temp_alarm_qualifier.sv
// tb/tb_temp_alarm_qualifier.sv - directed vector bench for temp_alarm_qualifier

module tb_temp_alarm_qualifier;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               temp_valid;
  logic signed [15:0] temp_code;
  logic signed [15:0] t_high;
  logic signed [15:0] t_low;
  logic [14:0]        hyst;
  logic               stats_clr;
  logic               warning;
  logic [2:0]         alarm_state;
  logic [7:0]         drop_cnt;
  logic signed [15:0] temp_min;
  logic signed [15:0] temp_max;

  int n_cmp = 0;
  int n_err = 0;

  temp_alarm_qualifier_if evt_if();

  temp_alarm_qualifier #(
    .DEBOUNCE  (3),
    .EVT_DEPTH (4),
    .TW        (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .temp_valid  (temp_valid),
    .temp_code   (temp_code),
    .t_high      (t_high),
    .t_low       (t_low),
    .hyst        (hyst),
    .stats_clr   (stats_clr),
    .warning     (warning),
    .alarm_state (alarm_state),
    .evt_if      (evt_if),
    .drop_cnt    (drop_cnt),
    .temp_min    (temp_min),
    .temp_max    (temp_max)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] temp;
    logic        clr;
    logic        rdy;
    logic [2:0]  st;
    logic        warn;
    logic        evv;
    logic [33:0] evd;
    logic [15:0] mn;
    logic [15:0] mx;
  } vec_t;

  vec_t vecs[21];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] t, input logic clr, input logic rdy);
    @(negedge clk);
    temp_valid       = v;
    temp_code        = t;
    stats_clr        = clr;
    evt_if.evt_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [15:0] t, input logic rdy);
    step(1'b1, t, 1'b0, rdy);
  endtask

  localparam logic [33:0] E0 = 34'd0;
  logic [1:0]  exp_type [4];
  logic [15:0] exp_temp [4];

  initial begin
    reset_n          = 1'b0;
    temp_valid       = 1'b0;
    temp_code        = 16'h0000;
    stats_clr        = 1'b0;
    evt_if.evt_ready = 1'b0;
    t_high           = 16'h0C80;
    t_low            = 16'h0000;
    hyst             = 15'h0100;

    vecs[0]  = '{1'b1, 16'h0D00, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, E0, 16'h0D00, 16'h0D00};
    vecs[1]  = '{1'b1, 16'h0D00, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, E0, 16'h0D00, 16'h0D00};
    vecs[2]  = '{1'b1, 16'h0D00, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, {2'd1, 16'h0002, 16'h0D00}, 16'h0D00, 16'h0D00};
    vecs[3]  = '{1'b1, 16'h0BC0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0, E0, 16'h0BC0, 16'h0D00};
    vecs[4]  = '{1'b1, 16'h0B80, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, {2'd3, 16'h0004, 16'h0B80}, 16'h0B80, 16'h0D00};
    vecs[5]  = '{1'b1, 16'h0D00, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, E0, 16'h0B80, 16'h0D00};
    vecs[6]  = '{1'b1, 16'h0D00, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, E0, 16'h0B80, 16'h0D00};
    vecs[7]  = '{1'b1, 16'h0C00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, E0, 16'h0B80, 16'h0D00};
    vecs[8]  = '{1'b0, 16'hFFFF, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, E0, 16'h0B80, 16'h0D00};
    vecs[9]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, E0, 16'h7FFF, 16'h8000};
    vecs[10] = '{1'b1, 16'hFFFB, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, E0, 16'hFFFB, 16'hFFFB};
    vecs[11] = '{1'b1, 16'h0009, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, E0, 16'hFFFB, 16'h0009};
    vecs[12] = '{1'b1, 16'h0014, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, E0, 16'h7FFF, 16'h8000};
    vecs[13] = '{1'b1, 16'h0003, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, E0, 16'h0003, 16'h0003};
    vecs[14] = '{1'b1, 16'hFF00, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, E0, 16'hFF00, 16'h0003};
    vecs[15] = '{1'b1, 16'hFF00, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, E0, 16'hFF00, 16'h0003};
    vecs[16] = '{1'b1, 16'hFF00, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, {2'd2, 16'h000E, 16'hFF00}, 16'hFF00, 16'h0003};
    vecs[17] = '{1'b1, 16'h00F0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0, E0, 16'hFF00, 16'h00F0};
    vecs[18] = '{1'b1, 16'h0D00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, {2'd3, 16'h0010, 16'h0D00}, 16'hFF00, 16'h0D00};
    vecs[19] = '{1'b1, 16'h0D00, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, E0, 16'hFF00, 16'h0D00};
    vecs[20] = '{1'b1, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, E0, 16'hFF00, 16'h0D00};

    repeat (2) @(posedge clk);
    #1;
    chk("reset state", 64'(alarm_state), 64'd0);
    chk("reset warning", 64'(warning), 64'd0);
    chk("reset evt_valid", 64'(evt_if.evt_valid), 64'd0);
    chk("reset evt_data", 64'(evt_if.evt_data), 64'd0);
    chk("reset drop_cnt", 64'(drop_cnt), 64'd0);
    chk("reset temp_min", 64'($unsigned(temp_min)), 64'h7FFF);
    chk("reset temp_max", 64'($unsigned(temp_max)), 64'h8000);

    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].v, vecs[i].temp, vecs[i].clr, vecs[i].rdy);
      chk($sformatf("v%0d state", i), 64'(alarm_state), 64'(vecs[i].st));
      chk($sformatf("v%0d warning", i), 64'(warning), 64'(vecs[i].warn));
      chk($sformatf("v%0d evt_valid", i), 64'(evt_if.evt_valid), 64'(vecs[i].evv));
      chk($sformatf("v%0d evt_data", i), 64'(evt_if.evt_data), 64'(vecs[i].evd));
      chk($sformatf("v%0d drop_cnt", i), 64'(drop_cnt), 64'd0);
      chk($sformatf("v%0d temp_min", i), 64'($unsigned(temp_min)), 64'(vecs[i].mn));
      chk($sformatf("v%0d temp_max", i), 64'($unsigned(temp_max)), 64'(vecs[i].mx));
    end

    // Overflow: six events with the consumer stalled.
    for (int k = 0; k < 3; k++) begin
      repeat (3) sample(16'h0D00, 1'b0);
      sample(16'h0B00, 1'b0);
    end
    chk("ovf drop_cnt", 64'(drop_cnt), 64'd2);
    chk("ovf evt_valid", 64'(evt_if.evt_valid), 64'd1);
    chk("ovf head type", 64'(evt_if.evt_data[33:32]), 64'd1);
    chk("ovf head temp", 64'(evt_if.evt_data[15:0]), 64'h0D00);

    // Push and pop on the same edge while full.
    repeat (2) sample(16'h0D00, 1'b0);
    sample(16'h0D00, 1'b1);
    chk("full push+pop drop_cnt", 64'(drop_cnt), 64'd2);
    chk("full push+pop state", 64'(alarm_state), 64'd2);
    exp_type[0] = 2'd3; exp_temp[0] = 16'h0B00;
    exp_type[1] = 2'd1; exp_temp[1] = 16'h0D00;
    exp_type[2] = 2'd3; exp_temp[2] = 16'h0B00;
    exp_type[3] = 2'd1; exp_temp[3] = 16'h0D00;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d valid", k), 64'(evt_if.evt_valid), 64'd1);
      chk($sformatf("drain%0d type", k), 64'(evt_if.evt_data[33:32]), 64'(exp_type[k]));
      chk($sformatf("drain%0d temp", k), 64'(evt_if.evt_data[15:0]), 64'(exp_temp[k]));
      step(1'b0, 16'h0000, 1'b0, 1'b1);
    end
    chk("drained evt_valid", 64'(evt_if.evt_valid), 64'd0);

    // Asynchronous reset while alarmed with an event queued.
    sample(16'h0B00, 1'b0);
    repeat (3) sample(16'h0D00, 1'b0);
    chk("pre-reset warning", 64'(warning), 64'd1);
    @(negedge clk);
    temp_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("midrst state", 64'(alarm_state), 64'd0);
    chk("midrst warning", 64'(warning), 64'd0);
    chk("midrst evt_valid", 64'(evt_if.evt_valid), 64'd0);
    chk("midrst drop_cnt", 64'(drop_cnt), 64'd0);
    chk("midrst temp_max", 64'($unsigned(temp_max)), 64'h8000);
    @(negedge clk);
    reset_n = 1'b1;

    // Low release level saturates at 0x7FFF.
    t_high = 16'h7FFF; t_low = 16'h7F00; hyst = 15'h7FFF;
    repeat (3) sample(16'h0000, 1'b0);
    chk("sat lo alarm", 64'(alarm_state), 64'd4);
    chk("sat lo event", 64'(evt_if.evt_data), 64'({2'd2, 16'h0002, 16'h0000}));
    sample(16'h7FFE, 1'b0);
    chk("sat lo 7FFE holds", 64'(alarm_state), 64'd4);
    sample(16'h7FFF, 1'b0);
    chk("sat lo 7FFF clears", 64'(alarm_state), 64'd0);

    // High release level saturates at 0x8000.
    t_high = 16'h8010; t_low = 16'h8000;
    repeat (3) sample(16'h0000, 1'b0);
    chk("sat hi alarm", 64'(alarm_state), 64'd2);
    sample(16'h8001, 1'b0);
    chk("sat hi 8001 holds", 64'(alarm_state), 64'd2);
    sample(16'h8000, 1'b0);
    chk("sat hi 8000 clears", 64'(alarm_state), 64'd0);

    // Raised threshold mid-pending applies to the next sample.
    t_high = 16'h0C80; t_low = 16'h0000; hyst = 15'h0100;
    repeat (2) sample(16'h0D00, 1'b0);
    chk("thr pend", 64'(alarm_state), 64'd1);
    t_high = 16'h0E00;
    sample(16'h0D00, 1'b0);
    chk("thr raised normal", 64'(alarm_state), 64'd0);
    chk("thr raised warning", 64'(warning), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
